bcd_converter: RTL and testbench
================================

# bcd_converter

Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) that sits directly upstream of the seven-segment display driver. It turns a binary count into packed BCD digits, plus an optional leading-zero blank mask. The display driver multiplexes these digits onto `an`/`seg`. A start/busy/done handshake lets a slow producer (counter, sensor) hand over one value at a time.

## Interface
- `BIN_W`, default 14: width of the binary input; the maximum representable value is 16383.
- `DIGITS`, default 4: number of BCD digits produced; display range 0 to 10^DIGITS−1.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request conversion of `bin`; sampled only in IDLE.
- `bin`  in  BIN_W: unsigned binary value; captured on the accepting edge.
- `busy`  out  1: high while a conversion is in flight (SHIFT and DONE).
- `done`  out  1: single-cycle pulse; `bcd`, `overflow` and `blank` are valid from this cycle onward.
- `bcd`  out  4·DIGITS: packed BCD, digit 0 (ones) in bits [3:0]; held until the next `done`.
- `overflow`  out  1: the captured `bin` exceeded 10^DIGITS−1.
- `blank`  out  DIGITS: per-digit blank mask for the display; 1 means blank this digit.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE:**
  - `start`=1 loads the working register with {DIGITS×4'b0, `bin`}.
  - The overflow flag is computed at this edge: `bin` > 10^DIGITS−1, compared at BIN_W+1 bits.
  - The bit counter is set to BIN_W and the FSM moves to SHIFT.
- **SHIFT:**
  - Each cycle, every BCD nibble ≥5 gets +3 (4-bit result, no carry out), then the whole register shifts left by 1.
  - The counter decrements each cycle. When it reaches 0 the FSM moves to DONE, so there are exactly BIN_W shift cycles.
- **DONE:**
  - Output registers update: `bcd` = the nibbles, or all 4'h9 if overflow (saturate). `overflow` is updated, and `blank` as described under Configuration.
  - `done`=1 for this cycle only, then the FSM returns to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor does it alter the in-flight operand.
- `start` held high continuously gives back-to-back conversions, with one IDLE cycle between them.
- `bin` = 0 gives `bcd`=0, `overflow`=0.
- `bin` = 10^DIGITS−1 gives all 9s with `overflow`=0.
- `bin` = 10^DIGITS gives all 9s with `overflow`=1.
- **Reset:** all outputs 0, FSM in IDLE, counter 0, working register 0.
- **Reset mid-conversion:** the operation is aborted immediately, no `done` pulse is produced, and outputs clear to 0.

## Timing
- Start accepted at edge k gives `done` high during the cycle after edge k+BIN_W+1. With the default that is 15 edges.
- Output registers change only at the DONE edge and are stable at all other times.
- `busy` rises the cycle after the accepting edge and falls together with `done`.
- Throughput is one conversion per BIN_W+2 cycles.
- No combinational path exists from inputs to outputs.

## Configuration
- **`BCD_LEADING_BLANK_EN` defined:**
  - At DONE, `blank[i]`=1 for each digit i ≥1 such that it and all higher digits are zero.
  - Digit 0 is never blanked.
  - When `overflow`=1, `blank` is all 0.
- **Undefined:** the `blank` port still exists and is tied to constant 0, with no blanking logic synthesized.

## Structure
- Package `bcd_pkg` holds:
  - the state enum `bcd_state_t` (IDLE, SHIFT, DONE);
  - the nibble typedef `bcd_digit_t` (logic [3:0]);
  - the constant function computing 10^DIGITS−1.
- Sub-module `bcd_add3` is a combinational single-nibble adjust (≥5 → +3). It is instantiated DIGITS times in a generate loop feeding the shift.
- The top level holds the FSM, bit counter, working register, overflow/blank logic and output registers.

## Test plan
- `bin`=1234, `start` pulse at edge 0 → `done` pulse after edge 15, `bcd`=16'h1234, `overflow`=0; with macro, `blank`=4'b0000.
- `bin`=0 → `bcd`=16'h0000; with macro, `blank`=4'b1110. Then `bin`=7 → `blank`=4'b1110; `bin`=40 → `blank`=4'b1100.
- `bin`=9999 → `bcd`=16'h9999, `overflow`=0. `bin`=10000 → `bcd`=16'h9999, `overflow`=1, `blank`=0. `bin`=16383 → same saturated result.
- `start` with `bin`=55, then `start` with `bin`=77 at edge 5 while `busy` → only one `done`, with `bcd`=16'h0055. `start` held high → two conversions with `done` pulses 16 cycles apart.
- `rst` asserted asynchronously mid-SHIFT (edge 7, `bin`=4321) → `busy`, `done` and `bcd` go to 0 immediately with no `done` pulse. A new start after release converts correctly.
- Randomized `bin` in 0..16383 (≥500 values) checked against a reference model of the decimal digits and the overflow rule.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;
    localparam bcd_digit_t ADD3_OFFSET    = 4'd3;

    // Largest value representable in `digits` decimal digits (10^digits - 1).
    function automatic int unsigned bcd_max_value(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-nibble adjust for shift-and-add-3: digits of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    // A 4-bit wrap is harmless: only overflowing inputs can reach 13+, and those saturate.
    assign dout = (din >= ADD3_THRESHOLD) ? bcd_digit_t'(din + ADD3_OFFSET) : din;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter, one input bit per cycle, start/busy/done handshake.
// Define BCD_LEADING_BLANK_EN to build the leading-zero blank mask; otherwise `blank` is tied to 0.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int WORK_W = 4 * DIGITS + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [BIN_W:0] MAX_VAL = (BIN_W + 1)'(bcd_max_value(DIGITS));

    bcd_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                overflow_q, overflow_d;

    logic [4*DIGITS-1:0] adj;
    logic [WORK_W-1:0]   adjusted;
    logic [WORK_W-1:0]   shifted;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (work_q[BIN_W + 4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    assign adjusted = {adj, work_q[BIN_W-1:0]};
    assign shifted  = adjusted << 1;

    // NOTE: every variable gets a default at the top of the block so no path leaves it
    // unassigned; that is what keeps this always_comb from inferring latches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d     = {{(4*DIGITS){1'b0}}, bin};
                    ovf_pend_d = ({1'b0, bin} > MAX_VAL);
                    cnt_d      = CNT_W'(BIN_W);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = ovf_pend_q ? {DIGITS{4'h9}} : work_q[WORK_W-1:BIN_W];
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              higher_zero;

    // A digit blanks only if it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_d     = blank_q;
        higher_zero = 1'b1;
        if (state_q == DONE) begin
            blank_d = '0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                higher_zero = higher_zero & (work_q[BIN_W + 4*i +: 4] == 4'd0);
                blank_d[i]  = higher_zero & ~ovf_pend_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: decimal reference model plus directed vectors.
module tb_bcd_converter;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    int tests  = 0;
    int failed = 0;

    bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow),
        .blank    (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected results straight from the decimal definition.
    function automatic void expect_of(input int v, output logic [4*DIGITS-1:0] b,
                                      output logic o, output logic [DIGITS-1:0] bl);
        int lim;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        o  = (v > lim - 1);
        b  = '0;
        bl = '0;
        for (int i = 0; i < DIGITS; i++) begin
            int p;
            p = 1;
            for (int j = 0; j < i; j++) p = p * 10;
            b[4*i +: 4] = o ? 4'h9 : 4'((v / p) % 10);
`ifdef BCD_LEADING_BLANK_EN
            if (i >= 1 && !o && v < p) bl[i] = 1'b1;
`endif
        end
    endfunction

    // Transaction-level model: an accepted start yields a result BIN_W+1 edges later.
    int                  m_remain = 0;
    int                  m_bin    = 0;
    logic                m_busy   = 1'b0;
    logic                m_done   = 1'b0;
    logic [4*DIGITS-1:0] m_bcd    = '0;
    logic                m_ovf    = 1'b0;
    logic [DIGITS-1:0]   m_blank  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_remain = 0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_bcd    = '0;
            m_ovf    = 1'b0;
            m_blank  = '0;
        end else begin
            m_done = 1'b0;
            if (m_remain == 0) begin
                if (start) begin
                    m_bin    = int'(bin);
                    m_remain = BIN_W + 1;
                    m_busy   = 1'b1;
                end
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    expect_of(m_bin, m_bcd, m_ovf, m_blank);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("blank", 32'(blank), 32'(m_blank));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One conversion with literal expectations; returns once the done cycle has passed.
    task automatic run_conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                            input logic [3:0] exp_blank_en);
        int n;
        logic [3:0] exp_blank;
`ifdef BCD_LEADING_BLANK_EN
        exp_blank = exp_blank_en;
`else
        exp_blank = 4'b0000;
`endif
        start = 1'b1;
        bin   = BIN_W'(v);
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 15);
        check("lit_bcd", 32'(bcd), 32'(exp_bcd));
        check("lit_ovf", 32'(overflow), 32'(exp_ovf));
        check("lit_blank", 32'(blank), 32'(exp_blank));
        tick();
        check("done_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int first_done;
        int second_done;
        logic [15:0] seen_bcd;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_bcd", 32'(bcd), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_blank", 32'(blank), 32'(0));
        tick();
        rst = 1'b0;
        tick();

        run_conv(1234,  16'h1234, 1'b0, 4'b0000);
        run_conv(0,     16'h0000, 1'b0, 4'b1110);
        run_conv(7,     16'h0007, 1'b0, 4'b1110);
        run_conv(40,    16'h0040, 1'b0, 4'b1100);
        run_conv(9999,  16'h9999, 1'b0, 4'b0000);
        run_conv(10000, 16'h9999, 1'b1, 4'b0000);
        run_conv(16383, 16'h9999, 1'b1, 4'b0000);
        run_conv(305,   16'h0305, 1'b0, 4'b1000);

        // A second start while busy must neither queue nor disturb the operand.
        start = 1'b1;
        bin   = BIN_W'(55);
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        bin   = BIN_W'(77);
        tick();
        start = 1'b0;
        n_done   = 0;
        seen_bcd = '0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                n_done++;
                seen_bcd = bcd;
            end
            tick();
        end
        check("busy_start_dones", n_done, 1);
        check("busy_start_bcd", 32'(seen_bcd), 32'h0055);

        // Start held high: back-to-back conversions BIN_W+2 cycles apart.
        start       = 1'b1;
        bin         = BIN_W'(321);
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i < 34; i++) begin
            tick();
            if (done) begin
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        check("held_gap", second_done - first_done, 16);
        repeat (20) tick();

        // Asynchronous reset in the middle of SHIFT aborts the conversion.
        start = 1'b1;
        bin   = BIN_W'(4321);
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_bcd", 32'(bcd), 32'(0));
        check("arst_ovf", 32'(overflow), 32'(0));
        tick();
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n_done++;
            tick();
        end
        check("arst_no_done", n_done, 0);
        run_conv(4321, 16'h4321, 1'b0, 4'b0000);

        // Random operands across the whole input range, checked by the model every cycle.
        for (int k = 0; k < 500; k++) begin
            int n;
            start = 1'b1;
            bin   = BIN_W'($urandom_range(16383, 0));
            tick();
            start = 1'b0;
            n = 0;
            while (!done && n < 40) begin
                tick();
                n++;
            end
            if (n >= 40) check("rand_timeout", n, 15);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
